// File: rtl/counter_ctrl_if.sv
// Command handshake between a run-command source and counter_ctrl.
// The master offers start/length/reload with valid; the slave answers with ready.
interface counter_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_len;
    logic             cmd_reload;

    modport master (
        output cmd_valid,
        output cmd_start,
        output cmd_len,
        output cmd_reload,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  cmd_len,
        input  cmd_reload,
        output cmd_ready
    );
endinterface

// File: rtl/counter_ctrl.sv
// Run-command sequencer for a loadable up-counter: load, enable for len increments,
// pulse done, and flag a sticky error if the fed-back count misses the target.
module counter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    counter_ctrl_if.slave    cmd,
    input  logic             abort,
    input  logic [WIDTH-1:0] count,
    output logic             load,
    output logic [WIDTH-1:0] load_value,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] len_reg;
    logic             reload_reg;
    logic [WIDTH-1:0] target_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] load_value_reg;
    logic             err_reg;
    logic             accept;

    assign cmd.cmd_ready = (state_reg == IDLE) && !abort && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    // Counter-facing outputs depend only on the state register, never on inputs.
    assign load       = (state_reg == LOAD);
    assign en         = (state_reg == RUN);
    assign done       = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);
    assign load_value = load_value_reg;
    assign err        = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            reload_reg     <= 1'b0;
            target_reg     <= '0;
            rem_reg        <= '0;
            load_value_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // load_value_reg doubles as the latched start value for reloads.
                        load_value_reg <= cmd.cmd_start;
                        len_reg        <= cmd.cmd_len;
                        reload_reg     <= cmd.cmd_reload;
                        target_reg     <= cmd.cmd_start + cmd.cmd_len;
                        err_reg        <= 1'b0;
                        state_reg      <= LOAD;
                    end
                end
                LOAD: begin
                    rem_reg <= len_reg;
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (len_reg != '0) begin
                        state_reg <= RUN;
                    end else begin
                        state_reg <= DONE;
                    end
                end
                RUN: begin
                    rem_reg <= rem_reg - WIDTH'(1);
                    if (abort) begin
                        state_reg <= IDLE;
                    end else if (rem_reg == WIDTH'(1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (abort) begin
                        state_reg <= IDLE;
                    end else begin
                        if (count != target_reg) begin
                            err_reg <= 1'b1;
                        end
                        state_reg <= reload_reg ? LOAD : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: drives run commands into the sequencer wired to an 8-bit
// counter and checks every cycle against a phase-based model plus literal expectations.
module tb_counter_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             abort = 1'b0;
    logic             stuck = 1'b0;
    logic [WIDTH-1:0] cnt;
    logic             load, en, busy, done, err;
    logic [WIDTH-1:0] load_value;

    int vectors = 0;
    int miscompares = 0;

    counter_ctrl_if #(.WIDTH(WIDTH)) cif ();

    counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cif.slave),
        .abort      (abort),
        .count      (cnt),
        .load       (load),
        .load_value (load_value),
        .en         (en),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // The real counter downstream; stuck models a disconnected enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               cnt <= '0;
        else if (load)         cnt <= load_value;
        else if (en && !stuck) cnt <= cnt + 8'd1;
    end

    // Model: a run is a sequence of phase numbers k = 0 (load), 1..len (increments), len+1 (done).
    bit       m_active;
    int       m_k;
    bit [7:0] m_start, m_len, m_count, m_lv;
    bit       m_reload, m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_k = 0; m_start = 0; m_len = 0;
            m_count = 0; m_lv = 0; m_reload = 0; m_err = 0;
        end else if (!m_active) begin
            if (cif.cmd_valid && !abort) begin
                m_active = 1; m_k = 0;
                m_start  = cif.cmd_start; m_len = cif.cmd_len;
                m_reload = cif.cmd_reload; m_lv = cif.cmd_start; m_err = 0;
            end
        end else begin
            if (m_k == 0) m_count = m_start;
            else if (m_k <= int'(m_len) && !stuck) m_count = m_count + 8'd1;
            if (abort) begin
                m_active = 0;
            end else if (m_k == int'(m_len) + 1) begin
                if (m_count != 8'(m_start + m_len)) m_err = 1;
                if (m_reload) m_k = 0;
                else m_active = 0;
            end else begin
                m_k = m_k + 1;
            end
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        chk("busy",       busy,       m_active);
        chk("load",       load,       m_active && m_k == 0);
        chk("en",         en,         m_active && m_k >= 1 && m_k <= int'(m_len));
        chk("done",       done,       m_active && m_k == int'(m_len) + 1);
        chk("cmd_ready",  cif.cmd_ready, !m_active && !abort && !rst);
        chk("load_value", load_value, m_lv);
        chk("err",        err,        m_err);
        chk("count",      cnt,        m_count);
    end

    task automatic issue(input logic [7:0] s, input logic [7:0] l, input logic r);
        @(posedge clk); #1;
        cif.cmd_valid = 1'b1; cif.cmd_start = s; cif.cmd_len = l; cif.cmd_reload = r;
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0;
        chk("accept_load", load, 1);
        chk("accept_lv", load_value, s);
        $display("cmd start=%0d len=%0d reload=%0d accepted at %0t", s, l, r, $time);
    endtask

    task automatic wait_done(input string name, input int exp_count);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin
                chk(name, cnt, exp_count);
                $display("%s: done with count=%0d at %0t", name, cnt, $time);
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: got no done pulse, expected one within 300 cycles", name);
    endtask

    initial begin
        int done_seen;
        cif.cmd_valid = 1'b0; cif.cmd_start = '0; cif.cmd_len = '0; cif.cmd_reload = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", cif.cmd_ready, 0);
        chk("rst_load", load, 0);
        #19 rst = 1'b0;
        #1;
        chk("post_rst_ready", cif.cmd_ready, 1);
        $display("reset released at %0t", $time);

        issue(8'd42, 8'd3, 1'b0);
        wait_done("oneshot", 45);
        @(posedge clk); #1;
        chk("oneshot_err", err, 0);
        chk("oneshot_ready", cif.cmd_ready, 1);

        issue(8'd254, 8'd4, 1'b0);
        wait_done("wrap", 2);
        @(posedge clk); #1;
        chk("wrap_err", err, 0);

        issue(8'd10, 8'd2, 1'b1);
        wait_done("reload1", 12);
        wait_done("reload2", 12);
        @(posedge clk); #1;
        chk("reload_lv", load_value, 10);
        @(posedge clk); #1;
        chk("reload_run_count", cnt, 10);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("reload_abort_en", en, 0);
        chk("reload_abort_busy", busy, 0);
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("reload_no_done", done_seen, 0);
        $display("auto-reload aborted at count=%0d", cnt);

        issue(8'd42, 8'd5, 1'b0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_count", cnt, 43);
        chk("abort_busy", busy, 0);
        chk("abort_no_done", done_seen, 0);
        $display("abort after one increment: count=%0d", cnt);

        @(posedge clk); #1;
        abort = 1'b1; cif.cmd_valid = 1'b1; cif.cmd_start = 8'd99; cif.cmd_len = 8'd1;
        #1 chk("abort_blocks_ready", cif.cmd_ready, 0);
        @(posedge clk); #1;
        cif.cmd_valid = 1'b0; abort = 1'b0;
        chk("abort_blocks_accept", busy, 0);
        $display("command blocked by abort in idle");

        issue(8'd7, 8'd0, 1'b0);
        wait_done("len0", 7);
        @(posedge clk); #1;
        chk("len0_err", err, 0);

        stuck = 1'b1;
        issue(8'd42, 8'd3, 1'b0);
        wait_done("stuck", 42);
        @(posedge clk); #1;
        chk("stuck_err", err, 1);
        stuck = 1'b0;

        issue(8'd5, 8'd1, 1'b0);
        chk("err_cleared", err, 0);
        wait_done("after_err", 6);
        @(posedge clk); #1;
        chk("after_err_err", err, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
